// File: rtl/axis_arb_pkg.sv
// Shared types and round-robin helper for the packet arbiter.
// Supports up to eight requesting sources.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int MAX_SRC = 8;

    // Search starts one past the last winner and wraps at n.
    function automatic int rr_winner(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         last,
        input int                 n
    );
        int   win;
        int   idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && req[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_rr_sel.sv
// Combinational round-robin picker over NUM_SRC request lines.
// Winner is only meaningful while any_req is high.
module axis_rr_sel
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int IW = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    logic [MAX_SRC-1:0] req_ext;
    logic [2:0]         last_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = req;
        last_ext               = '0;
        last_ext[IW-1:0]       = last_grant;
    end

    assign winner  = IW'(rr_winner(req_ext, last_ext, NUM_SRC));
    assign any_req = |req;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXIS arbiter with one registered output
// stage and a sticky oversize-packet flag.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 12,
    parameter int MAX_BEATS  = 1514,
    localparam int IW = $clog2(NUM_SRC)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_SRC-1:0]               s_axis_tvalid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_SRC*USER_WIDTH-1:0]    s_axis_tuser,
    input  logic [NUM_SRC-1:0]               s_axis_tlast,
    output logic [NUM_SRC-1:0]               s_axis_tready,
    output logic                             m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [IW-1:0]                    grant_idx,
    output logic                             busy,
    output logic                             err_oversize
);

    localparam int CW = $clog2(MAX_BEATS + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS + 1);

    arb_state_t state, state_nxt;

    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         winner;
    logic                  any_req;
    logic                  out_free;
    logic                  accept;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;
    logic [CW-1:0]         beat_cnt;
    logic [CW-1:0]         cnt_inc;

    axis_rr_sel #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_sel (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_user  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // Ready depends only on registered state and downstream ready.
    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign accept   = (state == XFER) & out_free & sel_valid;
    assign busy     = (state == XFER);
    assign cnt_inc  = (beat_cnt == CNT_SAT) ? beat_cnt : beat_cnt + 1'b1;

    always_comb begin
        s_axis_tready = '0;
        if (state == XFER) begin
            s_axis_tready[grant_idx] = out_free;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (any_req) state_nxt = XFER;
            XFER: if (accept && sel_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_idx  <= '0;
            last_grant <= IW'(NUM_SRC - 1);
        end else if (state == IDLE && any_req) begin
            grant_idx  <= winner;
            last_grant <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt     <= '0;
            err_oversize <= 1'b0;
        end else if (accept) begin
            beat_cnt <= sel_last ? '0 : cnt_inc;
            if (cnt_inc == CNT_SAT) begin
                err_oversize <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tuser  <= sel_user;
            m_axis_tlast  <= sel_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: queued byte sources, an output
// collector, and immediate-assertion checks against hand-written values.
module tb_axis_pkt_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int UW = 12;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NS-1:0]   s_axis_tvalid = '0;
    logic [NS*DW-1:0] s_axis_tdata = '0;
    logic [NS*UW-1:0] s_axis_tuser = '0;
    logic [NS-1:0]   s_axis_tlast = '0;
    logic [NS-1:0]   s_axis_tready;
    logic            m_axis_tvalid;
    logic [DW-1:0]   m_axis_tdata;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tlast;
    logic            m_axis_tready = 1'b1;
    logic [1:0]      grant_idx;
    logic            busy;
    logic            err_oversize;

    axis_pkt_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .err_oversize  (err_oversize)
    );

    always #5 clk = ~clk;

    logic [20:0] srcq [NS][$];
    logic [20:0] outq [$];
    int          grantq [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        hold_all = 1'b0;
    logic [NS-1:0] acc = '0;
    int          cyc = 0;
    int          tv_cyc = -1;
    int          mv_cyc = -1;
    logic        prev_busy = 1'b0;
    logic        err_seen = 1'b0;
    logic [7:0]  err_beat = '0;
    logic [7:0]  exp_d [12];
    int          exp_g [6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) acc = s_axis_tvalid & s_axis_tready;

    // Source model: pop accepted beats, present the next queued beat.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i] && srcq[i].size() > 0) srcq[i].delete(0);
            s_axis_tvalid[i] = hold_all || (srcq[i].size() > 0);
            if (srcq[i].size() > 0)
                {s_axis_tlast[i], s_axis_tuser[i*UW +: UW],
                 s_axis_tdata[i*DW +: DW]} = srcq[i][0];
            else
                {s_axis_tlast[i], s_axis_tuser[i*UW +: UW],
                 s_axis_tdata[i*DW +: DW]} = '0;
        end
        acc = '0;
    end

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready)
            outq.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
        if (busy && !prev_busy) grantq.push_back(int'(grant_idx));
        prev_busy = busy;
        if (!reset && s_axis_tvalid[2] && tv_cyc < 0) tv_cyc = cyc;
        if (m_axis_tvalid && tv_cyc >= 0 && mv_cyc < 0) mv_cyc = cyc;
        if (err_oversize && !err_seen) begin
            err_seen = 1'b1;
            err_beat = m_axis_tdata;
        end
    end

    function automatic logic [20:0] bt(input logic l, input logic [11:0] u,
                                       input logic [7:0] d);
        return {l, u, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int src, input logic [7:0] base,
                            input int n, input logic [11:0] u);
        for (int b = 0; b < n; b++)
            srcq[src].push_back(bt(b == n - 1, u, base + 8'(b)));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < NS; i++) srcq[i].delete();
        repeat (n) step();
        outq.delete();
        grantq.delete();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int k;
        logic empty;
        k = 0;
        empty = 1'b0;
        while (k < budget && !empty) begin
            step();
            k++;
            empty = !busy && !m_axis_tvalid;
            for (int i = 0; i < NS; i++)
                if (srcq[i].size() > 0) empty = 1'b0;
        end
        check(tag, 32'(empty), 32'd1);
    endtask

    initial begin
        int k;
        int tl_cnt;

        // Reset held with every source requesting
        reset = 1'b1;
        hold_all = 1'b1;
        repeat (3) step();
        check("rst_tready", 32'(s_axis_tready), 32'h0);
        check("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
        check("rst_grant", 32'(grant_idx), 32'h0);
        check("rst_err", 32'(err_oversize), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        hold_all = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Single packet from source 2
        srcq[2].push_back(bt(1'b0, 12'h003, 8'h30));
        srcq[2].push_back(bt(1'b0, 12'h003, 8'h31));
        srcq[2].push_back(bt(1'b1, 12'h003, 8'h0D));
        wait_drain(50, "pkt1_drain");
        check("pkt1_len", 32'(outq.size()), 32'd3);
        check("pkt1_b0", 32'(outq[0]), 32'(bt(1'b0, 12'h003, 8'h30)));
        check("pkt1_b1", 32'(outq[1]), 32'(bt(1'b0, 12'h003, 8'h31)));
        check("pkt1_b2", 32'(outq[2]), 32'(bt(1'b1, 12'h003, 8'h0D)));
        check("pkt1_lat", 32'(mv_cyc - tv_cyc), 32'd2);
        check("pkt1_grant", 32'(grantq[0]), 32'd2);

        // Contention between sources 0 and 1
        do_reset(2);
        push_pkt(0, 8'h10, 4, 12'h100);
        push_pkt(1, 8'h20, 4, 12'h101);
        wait_drain(80, "cont_drain");
        check("cont_len", 32'(outq.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check("cont_s0", 32'(outq[i]),
                  32'(bt(i == 3, 12'h100, 8'h10 + 8'(i))));
            check("cont_s1", 32'(outq[i+4]),
                  32'(bt(i == 3, 12'h101, 8'h20 + 8'(i))));
        end
        check("cont_ngrant", 32'(grantq.size()), 32'd2);
        check("cont_g0", 32'(grantq[0]), 32'd0);
        check("cont_g1", 32'(grantq[1]), 32'd1);

        // Fairness with every source requesting
        do_reset(2);
        push_pkt(0, 8'h40, 2, 12'h000);
        push_pkt(0, 8'h42, 2, 12'h000);
        push_pkt(1, 8'h50, 2, 12'h001);
        push_pkt(1, 8'h52, 2, 12'h001);
        push_pkt(2, 8'h60, 2, 12'h002);
        push_pkt(3, 8'h70, 2, 12'h003);
        exp_d = '{8'h40, 8'h41, 8'h50, 8'h51, 8'h60, 8'h61,
                  8'h70, 8'h71, 8'h42, 8'h43, 8'h52, 8'h53};
        exp_g = '{0, 1, 2, 3, 0, 1};
        wait_drain(120, "fair_drain");
        check("fair_ngrant", 32'(grantq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check("fair_grant", 32'(grantq[i]), 32'(exp_g[i]));
        check("fair_len", 32'(outq.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            check("fair_data", 32'(outq[i][7:0]), 32'(exp_d[i]));

        // Downstream backpressure mid-packet
        outq.delete();
        push_pkt(3, 8'hB0, 4, 12'h0B3);
        k = 0;
        while (!m_axis_tvalid && k < 50) begin
            step();
            k++;
        end
        check("bp_start", 32'(k < 50), 32'd1);
        step();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_data", 32'(m_axis_tdata), 32'h0B1);
            check("bp_hold_last", 32'(m_axis_tlast), 32'h0);
            check("bp_tready", 32'(s_axis_tready), 32'h0);
        end
        check("bp_srcq", 32'(srcq[3].size()), 32'd2);
        m_axis_tready = 1'b1;
        wait_drain(50, "bp_drain");
        check("bp_len", 32'(outq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("bp_data", 32'(outq[i]),
                  32'(bt(i == 3, 12'h0B3, 8'hB0 + 8'(i))));

        // Oversize packet: six beats against a four-beat limit
        check("ovs_pre", 32'(err_oversize), 32'h0);
        outq.delete();
        err_seen = 1'b0;
        push_pkt(1, 8'hC0, 6, 12'h0C1);
        wait_drain(60, "ovs_drain");
        check("ovs_err", 32'(err_oversize), 32'h1);
        check("ovs_beat", 32'(err_beat), 32'h0C4);
        check("ovs_len", 32'(outq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check("ovs_data", 32'(outq[i]),
                  32'(bt(i == 5, 12'h0C1, 8'hC0 + 8'(i))));

        // Reset arriving on the third beat of a packet
        outq.delete();
        push_pkt(2, 8'hD0, 4, 12'h0D2);
        k = 0;
        while (!(m_axis_tvalid && m_axis_tdata == 8'hD1) && k < 50) begin
            step();
            k++;
        end
        check("mrst_start", 32'(k < 50), 32'd1);
        step();
        reset = 1'b1;
        step();
        check("mrst_mvalid", 32'(m_axis_tvalid), 32'h0);
        check("mrst_mlast", 32'(m_axis_tlast), 32'h0);
        check("mrst_mdata", 32'(m_axis_tdata), 32'h0);
        check("mrst_muser", 32'(m_axis_tuser), 32'h0);
        check("mrst_tready", 32'(s_axis_tready), 32'h0);
        check("mrst_grant", 32'(grant_idx), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_err", 32'(err_oversize), 32'h0);
        tl_cnt = 0;
        foreach (outq[i]) if (outq[i][20]) tl_cnt++;
        check("mrst_no_last", 32'(tl_cnt), 32'd0);
        do_reset(2);
        repeat (4) step();
        check("post_idle", 32'(m_axis_tvalid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
